// File: rtl/serial_frame_loader.sv
// Receives the MCU's three-wire LED update stream, assembles and length-checks a
// 96-bit frame, and commits per-digit segment/anode masks atomically on latch.
module serial_frame_loader #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 20800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_clk,
    input  logic       ser_data,
    input  logic       ser_latch,
    output logic [6:0] red_d1,
    output logic [6:0] red_d2,
    output logic [6:0] red_d3,
    output logic [6:0] red_d4,
    output logic [6:0] grn_d1,
    output logic [6:0] grn_d2,
    output logic [6:0] grn_d3,
    output logic [6:0] grn_d4,
    output logic [5:0] leda_d1,
    output logic [5:0] leda_d2,
    output logic [5:0] leda_d3,
    output logic [5:0] leda_d4,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [6:0]  FULL_COUNT = 7'd96;
    localparam logic [6:0]  OVF_COUNT  = 7'd97;
    localparam logic [14:0] TMO_LAST   = 15'(TIMEOUT_CYCLES - 1);

    // Lane order: 0 = ser_clk, 1 = ser_data, 2 = ser_latch. Identical depth keeps
    // data aligned with the clock edge that samples it.
    logic [2:0] line_in;
    logic [2:0] line_sync;

    assign line_in = {ser_latch, ser_data, ser_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] stage_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= '1;
                end else begin
                    stage_reg <= {stage_reg[SYNC_STAGES-2:0], line_in[gi]};
                end
            end

            assign line_sync[gi] = stage_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic clk_hist_reg;
    logic latch_hist_reg;
    logic clk_rise;
    logic latch_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_hist_reg   <= 1'b1;
            latch_hist_reg <= 1'b1;
        end else begin
            clk_hist_reg   <= line_sync[0];
            latch_hist_reg <= line_sync[2];
        end
    end

    assign clk_rise   = line_sync[0] & ~clk_hist_reg;
    assign latch_rise = line_sync[2] & ~latch_hist_reg;

    // The oldest of the 96 bits is an ignored slot (digit 4, bit 23), so only
    // the newest 95 bits need storage.
    logic [94:0] shreg_reg;
    logic [94:0] shreg_next;
    logic [6:0]  bit_cnt_reg;
    logic [6:0]  bit_cnt_shift;
    logic [6:0]  bit_cnt_next;
    logic [14:0] tmo_reg;
    logic [14:0] tmo_next;
    logic        load_next;
    logic        valid_next;
    logic        err_next;

    always_comb begin
        shreg_next    = shreg_reg;
        bit_cnt_shift = bit_cnt_reg;
        tmo_next      = tmo_reg;
        load_next     = 1'b0;
        valid_next    = 1'b0;
        err_next      = 1'b0;

        if (clk_rise) begin
            shreg_next = {shreg_reg[93:0], line_sync[1]};
            if (bit_cnt_reg != OVF_COUNT) begin
                bit_cnt_shift = bit_cnt_reg + 7'd1;
            end
            tmo_next = '0;
        end else if (bit_cnt_reg != 7'd0) begin
            tmo_next = tmo_reg + 15'd1;
        end

        bit_cnt_next = bit_cnt_shift;

        // Length check sees the post-shift count so a latch coincident with the
        // final bit still commits.
        if (latch_rise) begin
            bit_cnt_next = '0;
            tmo_next     = '0;
            if (bit_cnt_shift == FULL_COUNT) begin
                load_next  = 1'b1;
                valid_next = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end else if (!clk_rise && bit_cnt_reg != 7'd0 && tmo_reg == TMO_LAST) begin
            bit_cnt_next = '0;
            tmo_next     = '0;
            err_next     = 1'b1;
        end
    end

    logic [3:0][6:0] red_reg;
    logic [3:0][6:0] grn_reg;
    logic [3:0][5:0] leda_reg;
    logic            valid_reg;
    logic            err_reg;
    logic            busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            tmo_reg     <= '0;
            red_reg     <= '0;
            grn_reg     <= '0;
            leda_reg    <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= bit_cnt_next;
            tmo_reg     <= tmo_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
            busy_reg    <= (bit_cnt_next != 7'd0);
            if (load_next) begin
                for (int d = 0; d < 4; d++) begin
                    red_reg[d]  <= shreg_next[24*d+16 +: 7];
                    grn_reg[d]  <= shreg_next[24*d+8 +: 7];
                    leda_reg[d] <= shreg_next[24*d +: 6];
                end
            end
        end
    end

    assign red_d1      = red_reg[0];
    assign red_d2      = red_reg[1];
    assign red_d3      = red_reg[2];
    assign red_d4      = red_reg[3];
    assign grn_d1      = grn_reg[0];
    assign grn_d2      = grn_reg[1];
    assign grn_d3      = grn_reg[2];
    assign grn_d4      = grn_reg[3];
    assign leda_d1     = leda_reg[0];
    assign leda_d2     = leda_reg[1];
    assign leda_d3     = leda_reg[2];
    assign leda_d4     = leda_reg[3];
    assign frame_valid = valid_reg;
    assign frame_err   = err_reg;
    assign busy        = busy_reg;

endmodule

// File: doc/serial_frame_loader.md
Name: serial_frame_loader

Overview:
- Upstream stage of the multiplexed LED digit driver. Receives the microcontroller's three-wire update stream (serial clock, data, latch), which is asynchronous to the FPGA oscillator.
- Synchronises the stream into the oscillator domain, assembles a 96-bit frame and checks its length.
- On a valid latch, commits per-digit red/green segment masks and anode enables as stable registered outputs, and pulses a strobe.
- Malformed or stalled transfers are rejected and flagged. The previously displayed frame is kept.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (legal range 2..4).
- TIMEOUT_CYCLES, 20800, clk cycles with no ser_clk rising edge before a partial frame is discarded (10 ms at 2.08 MHz). Legal range 2..32767.

Ports:
- clk  input  1  oscillator-domain clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ser_clk  input  1  MCU serial clock, asynchronous; data is sampled on its rising edge.
- ser_data  input  1  MCU serial data, asynchronous, MSB of the frame first.
- ser_latch  input  1  MCU latch, asynchronous; its rising edge requests a commit.
- red_d1, red_d2, red_d3, red_d4  output  7 each  red segment masks for digits 1-4.
- grn_d1, grn_d2, grn_d3, grn_d4  output  7 each  green segment masks for digits 1-4.
- leda_d1, leda_d2, leda_d3, leda_d4  output  6 each  LED anode enables for digits 1-4.
- frame_valid  output  1  one-cycle pulse, asserted on the cycle the outputs update.
- frame_err  output  1  one-cycle pulse for a wrong-length latch or a timeout.
- busy  output  1  high while a partial frame is held (bit count nonzero).

Behaviour:
- Synchronisation:
  - ser_clk, ser_data and ser_latch each pass through a SYNC_STAGES synchroniser, followed by one history flop.
  - Rising edge = synchronised value is 1 and history is 0.
  - All synchroniser and history flops reset to 1, so a line held high through reset produces no edge.
  - ser_data travels through an identical chain, so it stays aligned with ser_clk.
- Shift:
  - On a detected ser_clk rising edge: shreg <= {shreg[94:0], data_sync} and bit_cnt increments.
  - bit_cnt is 7 bits and saturates at 97 (overflow marker).
- Frame map, with digit N occupying bits [24N-1 : 24N-24]:
  - red = [22:16], grn = [14:8], leda = [5:0] of that 24-bit slice.
  - Bits 23, 15, 7 and 6 of each slice are ignored.
  - Digit 4 is shifted in first; digit 1 is shifted in last.
- Latch: on a detected ser_latch rising edge, evaluated in the same cycle:
  - If bit_cnt == 96: on the next clk edge all twelve outputs load from shreg and frame_valid = 1 for that one cycle.
  - Otherwise (under 96, or 97 meaning overflow): outputs are held and frame_err = 1 for one cycle.
  - In both cases bit_cnt <= 0 and the timeout counter <= 0.
- Simultaneous ser_clk and ser_latch edges in the same cycle: the bit is shifted first, and the length check uses the post-shift count and register contents.
- Timeout:
  - A 15-bit counter runs while bit_cnt != 0 and clears on every ser_clk edge.
  - When it reaches TIMEOUT_CYCLES-1 with no edge: bit_cnt <= 0, counter <= 0, frame_err pulses for one cycle, outputs are held.
  - A latch arriving in the same cycle takes priority over the timeout.
- busy = (bit_cnt != 0), registered.
- Latency: an MCU latch edge appears as updated outputs SYNC_STAGES+2 clk cycles later (±1 cycle of synchroniser uncertainty).
- Reset:
  - All digit outputs, frame_valid, frame_err, busy, bit_cnt, shreg and the timeout counter go to 0. Synchroniser and history flops go to 1.
  - Reset mid-frame discards the partial frame. The next frame starts from bit_cnt = 0.
- The outputs change only on the commit cycle, so the downstream driver never sees a partially updated frame.

Test Plan:
- Reset, then shift 96 bits with digit1 red=7'h55, grn=7'h2A, leda=6'h3F and digits 2-4 all zero, then latch -> frame_valid pulses once; red_d1=55, grn_d1=2A, leda_d1=3F; all other digit outputs 0; busy falls to 0.
- After a good frame, shift 95 bits of all ones, then latch -> frame_err pulses once; all outputs unchanged; frame_valid stays 0.
- Shift 100 bits, then latch -> frame_err pulses (overflow, count saturated at 97); outputs unchanged; the next 96-bit frame commits correctly.
- Shift 40 bits, then idle TIMEOUT_CYCLES clk cycles (parameter set to 50 for the test) -> frame_err pulses at cycle 49 and busy drops; a following 96-bit frame commits.
- Shift 60 bits, assert rst for one cycle, then send a full 96-bit frame -> outputs are all 0 after reset, then reflect the new frame only; no frame_err.
- Drive the 96th ser_clk rising edge and the ser_latch rising edge together -> commit succeeds, and the final bit lands in leda_d1[0].
